// File: rtl/sipo_encrypt_piso.sv
// Scan-path encryption front end: serial plaintext in, AES core handshake, serial ciphertext out.
// The next block shifts in while the current ciphertext shifts out.
module sipo_encrypt_piso #(
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             serial_in,
  input  logic [BLK_W-1:0] key_in,
  output logic             serial_out,
  output logic             ct_valid,
  output logic             busy,
  output logic             core_start,
  output logic [BLK_W-1:0] core_pt,
  output logic [BLK_W-1:0] core_key,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_ct
);

  localparam int unsigned CNT_W = $clog2(BLK_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_W - 1);

  typedef enum logic [1:0] {FILL, START, WAIT, STREAM} state_t;

  state_t           state, state_nxt;
  logic [BLK_W-1:0] in_sr, in_sr_nxt;
  logic [BLK_W-1:0] out_sr, out_sr_nxt;
  logic [CNT_W-1:0] in_cnt, in_cnt_nxt;
  logic [CNT_W-1:0] out_cnt, out_cnt_nxt;
  logic             in_take;
  logic             in_full;
  logic             load_core;

  // State, shift registers and registered outputs (outputs follow the next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      in_sr      <= '0;
      out_sr     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      serial_out <= 1'b0;
      ct_valid   <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_pt    <= '0;
      core_key   <= '0;
    end else begin
      state      <= state_nxt;
      in_sr      <= in_sr_nxt;
      out_sr     <= out_sr_nxt;
      in_cnt     <= in_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
      serial_out <= (state_nxt == STREAM) ? out_sr_nxt[BLK_W-1] : 1'b0;
      ct_valid   <= (state_nxt == STREAM);
      busy       <= (state_nxt == START) || (state_nxt == WAIT);
      core_start <= (state_nxt == START);
      // Operands are latched on entry to START so they are valid alongside core_start
      if (load_core) begin
        core_pt  <= in_sr_nxt;
        core_key <= key_in;
      end
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt   = state;
    in_sr_nxt   = in_sr;
    out_sr_nxt  = out_sr;
    in_cnt_nxt  = in_cnt;
    out_cnt_nxt = out_cnt;
    load_core   = 1'b0;
    in_full     = 1'b0;
    in_take     = en && ((state == FILL) || (state == STREAM));

    if (in_take) begin
      in_sr_nxt = {in_sr[BLK_W-2:0], serial_in};
      if (in_cnt == CNT_LAST) begin
        in_cnt_nxt = '0;
        in_full    = 1'b1;
      end else begin
        in_cnt_nxt = in_cnt + CNT_W'(1);
      end
    end

    unique case (state)
      FILL: begin
        if (in_full) begin
          state_nxt = START;
          load_core = 1'b1;
        end
      end
      START: begin
        in_cnt_nxt = '0;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          out_sr_nxt  = core_ct;
          out_cnt_nxt = '0;
          state_nxt   = STREAM;
        end
      end
      STREAM: begin
        if (en) begin
          out_sr_nxt = {out_sr[BLK_W-2:0], 1'b0};
          if (out_cnt == CNT_LAST) begin
            out_cnt_nxt = '0;
            state_nxt   = in_full ? START : FILL;
            load_core   = in_full;
          end else begin
            out_cnt_nxt = out_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

endmodule
